// File: rtl/rst_seq_gen_if.sv
// Reset-sequencer request/status bundle: raw request in, stretched reset pulse and debug status out.
// Ports: rst_req (request level), rst_out (active-high reset pulse), busy, done (1-cycle), pulse_cnt.
// slave = sequencer side, master = requester/observer side.
interface rst_seq_gen_if #(
  parameter int CNT_W = 8
);
  logic             rst_req;
  logic             rst_out;
  logic             busy;
  logic             done;
  logic [CNT_W-1:0] pulse_cnt;

  modport slave (
    input  rst_req,
    output rst_out,
    output busy,
    output done,
    output pulse_cnt
  );

  modport master (
    output rst_req,
    input  rst_out,
    input  busy,
    input  done,
    input  pulse_cnt
  );
endinterface

// File: rtl/rst_seq_gen.sv
// Reset sequencer: debounces rst_req, then issues a HOLD_CYC-long registered reset pulse followed by a cooldown.
// Latency: rst_out rises one cycle after the DEB_CYC+1-th consecutive high sample of rst_req; all outputs registered.
// Ports: clk, reset (sync, active-high) plus bus (slave): rst_req in; rst_out, busy, done, pulse_cnt out.
module rst_seq_gen #(
  parameter int DEB_CYC  = 4,
  parameter int HOLD_CYC = 16,
  parameter int COOL_CYC = 8,
  parameter int CNT_W    = 8
) (
  input  logic        clk,
  input  logic        reset,
  rst_seq_gen_if.slave bus
);

  localparam int MAXC = (DEB_CYC > HOLD_CYC) ?
                        ((DEB_CYC > COOL_CYC) ? DEB_CYC : COOL_CYC) :
                        ((HOLD_CYC > COOL_CYC) ? HOLD_CYC : COOL_CYC);
  localparam int CW   = $clog2(MAXC + 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    ASSERT   = 2'd2,
    COOLDOWN = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             rst_out_q, rst_out_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] pcnt_q, pcnt_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      // Reset lands directly in ASSERT so the power-on stretch reuses the normal hold path.
      state_q   <= ASSERT;
      cnt_q     <= CW'(HOLD_CYC - 1);
      rst_out_q <= 1'b1;
      busy_q    <= 1'b1;
      done_q    <= 1'b0;
      pcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rst_out_q <= rst_out_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pcnt_q    <= pcnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rst_out_d = 1'b0;
    done_d    = 1'b0;
    pcnt_d    = pcnt_q;
    case (state_q)
      IDLE: begin
        if (bus.rst_req) begin
          state_d = DEBOUNCE;
          cnt_d   = CW'(DEB_CYC - 1);
        end
      end
      DEBOUNCE: begin
        if (!bus.rst_req) begin
          state_d = IDLE;
        end else if (cnt_q == '0) begin
          state_d   = ASSERT;
          cnt_d     = CW'(HOLD_CYC - 1);
          rst_out_d = 1'b1;
          // Saturate so a stuck request never wraps the debug count.
          if (pcnt_q != '1) pcnt_d = pcnt_q + 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ASSERT: begin
        if (cnt_q == '0) begin
          state_d = COOLDOWN;
          cnt_d   = CW'(COOL_CYC - 1);
          done_d  = 1'b1;
        end else begin
          cnt_d     = cnt_q - 1'b1;
          rst_out_d = 1'b1;
        end
      end
      COOLDOWN: begin
        if (cnt_q == '0) state_d = IDLE;
        else             cnt_d   = cnt_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
    // busy is a registered copy of "next state is not IDLE".
    busy_d = (state_d != IDLE);
  end

  assign bus.rst_out   = rst_out_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.pulse_cnt = pcnt_q;

endmodule
